rtc_bus_seq: RTL and testbench

Parametrised register-access sequencer for the RTC parallel bus, driven by the chronometer/clock-setting control logic. On a start request it latches and range-checks a register address, then drives timed RD and/or WR strobes according to a selectable mode. It signals completion with a one-cycle `ready` pulse. It generalises the fixed read-then-write chronometer sequencer with configurable address range, strobe lengths, access mode, abort and error reporting, and guaranteed non-overlapping strobes.

---
 rtl/rtc_bus_seq.sv | 161 ++++++++++++++++
 tb/tb_rtc_bus_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_seq.sv
// Register-access sequencer for the RTC parallel bus.
// Latches and range-checks an address, then drives timed RD and/or WR strobes.
// Completion is a one-cycle ready pulse. Every output is registered.
module rtc_bus_seq #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned ADDR_MIN     = 1,
    parameter int unsigned ADDR_MAX     = 4,
    parameter int unsigned ADDR_DEFAULT = 1,
    parameter int unsigned RD_CYC       = 257,
    parameter int unsigned WR_CYC       = 256,
    parameter int unsigned CNT_W        = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              abort,
    input  logic [ADDR_W-1:0] dir_in,
    output logic [ADDR_W-1:0] dir_out,
    output logic              RD,
    output logic              WR,
    output logic              busy,
    output logic              ready,
    output logic              aborted,
    output logic              addr_err
);

    localparam logic [ADDR_W-1:0] AddrLo  = ADDR_W'(ADDR_MIN);
    localparam logic [ADDR_W-1:0] AddrHi  = ADDR_W'(ADDR_MAX);
    localparam logic [ADDR_W-1:0] AddrDef = ADDR_W'(ADDR_DEFAULT);
    localparam logic [CNT_W-1:0]  RdLoad  = CNT_W'(RD_CYC - 1);
    localparam logic [CNT_W-1:0]  WrLoad  = CNT_W'(WR_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StRdPh,
        StGap,
        StWrPh,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] dir_q, dir_d;
    logic              err_q, err_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              aborted_q, aborted_d;
    logic              addr_ok;
    logic              wr_only;

    assign addr_ok = (dir_in >= AddrLo) && (dir_in <= AddrHi);
    // Mode 11 behaves as read-then-write, so only 01 skips the read phase.
    assign wr_only = (mode_q == 2'b01);

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        dir_d     = dir_q;
        err_d     = err_q;
        aborted_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d  = mode;
                    // Checked address is registered here so dir_out is valid while in LATCH.
                    dir_d   = addr_ok ? dir_in : AddrDef;
                    err_d   = ~addr_ok;
                    state_d = StLatch;
                end
            end
            StLatch: begin
                if (wr_only) begin
                    state_d = StWrPh;
                    cnt_d   = WrLoad;
                end else begin
                    state_d = StRdPh;
                    cnt_d   = RdLoad;
                end
            end
            StRdPh: begin
                if (cnt_q == '0) begin
                    state_d = mode_q[1] ? StGap : StDone;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StGap: begin
                state_d = StWrPh;
                cnt_d   = WrLoad;
            end
            StWrPh: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides any transition, including counter expiry.
        if (abort && (state_q != StIdle)) begin
            state_d   = StIdle;
            aborted_d = 1'b1;
        end

        rd_d    = (state_d == StRdPh);
        wr_d    = (state_d == StWrPh);
        busy_d  = (state_d != StIdle);
        ready_d = (state_d == StDone);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            mode_q    <= 2'b00;
            dir_q     <= AddrDef;
            err_q     <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            aborted_q <= aborted_d;
        end
    end

    assign dir_out  = dir_q;
    assign addr_err = err_q;
    assign RD       = rd_q;
    assign WR       = wr_q;
    assign busy     = busy_q;
    assign ready    = ready_q;
    assign aborted  = aborted_q;

endmodule

// File: tb/tb_rtc_bus_seq.sv
// Bench for rtc_bus_seq: one default-parameter instance (0) and one short-strobe instance (1).
// A timeline model predicts every output of both instances each cycle.
module tb_rtc_bus_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rstn_v, start_v, abort_v;
    logic [1:0] mode_v [2];
    logic [7:0] dir_v  [2];
    logic [1:0] rd_o, wr_o, busy_o, ready_o, ab_o, err_o;
    logic [7:0] dout_o [2];

    rtc_bus_seq dut_def (
        .clk(clk), .reset_n(rstn_v[0]), .start(start_v[0]), .mode(mode_v[0]),
        .abort(abort_v[0]), .dir_in(dir_v[0]), .dir_out(dout_o[0]), .RD(rd_o[0]),
        .WR(wr_o[0]), .busy(busy_o[0]), .ready(ready_o[0]), .aborted(ab_o[0]),
        .addr_err(err_o[0])
    );

    rtc_bus_seq #(.RD_CYC(4), .WR_CYC(3), .CNT_W(3)) dut_small (
        .clk(clk), .reset_n(rstn_v[1]), .start(start_v[1]), .mode(mode_v[1]),
        .abort(abort_v[1]), .dir_in(dir_v[1]), .dir_out(dout_o[1]), .RD(rd_o[1]),
        .WR(wr_o[1]), .busy(busy_o[1]), .ready(ready_o[1]), .aborted(ab_o[1]),
        .addr_err(err_o[1])
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rdc [2];
    int wrc [2];

    // Transaction timeline model: start cycle, ready cycle, mode, abort pulse cycle.
    int m_active [2];
    int m_s      [2];
    int m_e      [2];
    int m_md     [2];
    int m_abc    [2];
    logic [7:0] m_dir [2];
    logic       m_err [2];

    typedef struct {
        logic       start;
        logic [1:0] mode;
        logic       abort;
        logic [7:0] dir;
        logic       e_rd;
        logic       e_wr;
        logic       e_busy;
        logic       e_ready;
        logic       e_aborted;
        logic [7:0] e_dir;
        logic       e_err;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(logic st, logic rd, logic wr, logic bz, logic rdy);
        vec_t v;
        v.start = st;   v.mode = 2'd2;  v.abort = 1'b0; v.dir = 8'd3;
        v.e_rd = rd;    v.e_wr = wr;    v.e_busy = bz;  v.e_ready = rdy;
        v.e_aborted = 1'b0; v.e_dir = 8'd3; v.e_err = 1'b0;
        return v;
    endfunction

    function automatic bit in_rng(int c, int lo, int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    function automatic bit m_busy(int i, int c);
        return (m_active[i] != 0) && in_rng(c, m_s[i] + 1, m_e[i]);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Apply the rules to the inputs sampled in cycle k.
    task automatic model_edge(int i, int k);
        if (!rstn_v[i]) begin
            m_active[i] = 0; m_dir[i] = 8'd1; m_err[i] = 1'b0; m_abc[i] = -1;
        end else if (m_busy(i, k)) begin
            if (abort_v[i]) begin
                m_active[i] = 0;
                m_abc[i]    = k + 1;
            end
        end else if (start_v[i]) begin
            m_active[i] = 1;
            m_s[i]      = k;
            m_md[i]     = (mode_v[i] == 2'b00) ? 0 : (mode_v[i] == 2'b01) ? 1 : 2;
            if (m_md[i] == 0)      m_e[i] = k + rdc[i] + 2;
            else if (m_md[i] == 1) m_e[i] = k + wrc[i] + 2;
            else                   m_e[i] = k + rdc[i] + wrc[i] + 3;
            if (dir_v[i] >= 8'd1 && dir_v[i] <= 8'd4) begin
                m_dir[i] = dir_v[i]; m_err[i] = 1'b0;
            end else begin
                m_dir[i] = 8'd1;     m_err[i] = 1'b1;
            end
        end
    endtask

    task automatic model_check(int i);
        int  c, s;
        bit  act, e_rd, e_wr;
        c   = cyc;
        s   = m_s[i];
        act = (m_active[i] != 0);
        e_rd = act && (m_md[i] != 1) && in_rng(c, s + 2, s + rdc[i] + 1);
        e_wr = act && (((m_md[i] == 1) && in_rng(c, s + 2, s + wrc[i] + 1)) ||
               ((m_md[i] == 2) && in_rng(c, s + rdc[i] + 3, s + rdc[i] + wrc[i] + 2)));
        check($sformatf("m%0d.busy", i), busy_o[i], m_busy(i, c));
        check($sformatf("m%0d.rd", i), rd_o[i], e_rd);
        check($sformatf("m%0d.wr", i), wr_o[i], e_wr);
        check($sformatf("m%0d.ready", i), ready_o[i], act && (c == m_e[i]));
        check($sformatf("m%0d.aborted", i), ab_o[i], c == m_abc[i]);
        check($sformatf("m%0d.dir_out", i), dout_o[i], m_dir[i]);
        check($sformatf("m%0d.addr_err", i), err_o[i], m_err[i]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0, cyc);
        model_edge(1, cyc);
        cyc++;
        @(negedge clk);
        model_check(0);
        model_check(1);
    endtask

    task automatic quiet(int i);
        start_v[i] = 1'b0; abort_v[i] = 1'b0; rstn_v[i] = 1'b1;
    endtask

    task automatic wait_idle(int i);
        for (int n = 0; n < 1000 && m_busy(i, cyc); n++) step();
    endtask

    // Drive one default-instance transaction; report strobe counts and ready cycle.
    task automatic run_def(input logic [1:0] md, input logic [7:0] d,
                           output int rd_cnt, output int wr_cnt, output int rdy_at);
        rd_cnt = 0; wr_cnt = 0; rdy_at = -1;
        start_v[0] = 1'b1; mode_v[0] = md; dir_v[0] = d;
        step();
        start_v[0] = 1'b0;
        for (int n = 2; n < 600; n++) begin
            step();
            rd_cnt += int'(rd_o[0]);
            wr_cnt += int'(wr_o[0]);
            if (ready_o[0] && rdy_at < 0) rdy_at = n;
            if (!busy_o[0]) break;
        end
    endtask

    int rc, wc, ra, nrdy;

    initial begin
        rdc[0] = 257; wrc[0] = 256; rdc[1] = 4; wrc[1] = 3;
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 0; m_s[i] = 0; m_e[i] = 0; m_md[i] = 0; m_abc[i] = -1;
            m_dir[i] = 8'd1; m_err[i] = 1'b0;
            mode_v[i] = 2'b00; dir_v[i] = 8'd0;
        end
        rstn_v = 2'b00; start_v = 2'b00; abort_v = 2'b00;

        // Reset state.
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            check("rst.rd", rd_o[i], 0);
            check("rst.busy", busy_o[i], 0);
            check("rst.ready", ready_o[i], 0);
            check("rst.dir_out", dout_o[i], 8'd1);
            check("rst.addr_err", err_o[i], 0);
        end
        quiet(0); quiet(1);
        step();

        // Read-then-write on the short instance, row k gives the outputs of cycle k+1.
        tbl[0] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int r = 1; r <= 4; r++) tbl[r] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[5] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int r = 6; r <= 8; r++) tbl[r] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[9]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tbl[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 11; r++) begin
            start_v[1] = tbl[r].start; mode_v[1] = tbl[r].mode;
            abort_v[1] = tbl[r].abort; dir_v[1]  = tbl[r].dir;
            step();
            check($sformatf("tbl%0d.rd", r), rd_o[1], tbl[r].e_rd);
            check($sformatf("tbl%0d.wr", r), wr_o[1], tbl[r].e_wr);
            check($sformatf("tbl%0d.busy", r), busy_o[1], tbl[r].e_busy);
            check($sformatf("tbl%0d.ready", r), ready_o[1], tbl[r].e_ready);
            check($sformatf("tbl%0d.aborted", r), ab_o[1], tbl[r].e_aborted);
            check($sformatf("tbl%0d.dir_out", r), dout_o[1], tbl[r].e_dir);
            check($sformatf("tbl%0d.addr_err", r), err_o[1], tbl[r].e_err);
        end

        // Reset held for three cycles in the middle of RD_PH.
        start_v[1] = 1'b1; mode_v[1] = 2'b00; dir_v[1] = 8'd3;
        step();
        start_v[1] = 1'b0;
        step(); step();
        check("rstmid.rd_before", rd_o[1], 1);
        rstn_v[1] = 1'b0;
        repeat (3) begin
            step();
            check("rstmid.rd", rd_o[1], 0);
            check("rstmid.busy", busy_o[1], 0);
            check("rstmid.dir_out", dout_o[1], 8'd1);
            check("rstmid.ready", ready_o[1], 0);
        end
        rstn_v[1] = 1'b1;
        repeat (5) begin
            step();
            check("rstmid.no_ready", ready_o[1], 0);
        end

        // Illegal address, default strobe lengths, read mode.
        run_def(2'b00, 8'd9, rc, wc, ra);
        check("illegal.dir_out", dout_o[0], 8'd1);
        check("illegal.addr_err", err_o[0], 1);
        check("illegal.rd_cycles", rc, 257);
        check("illegal.wr_cycles", wc, 0);
        check("illegal.ready_cycle", ra, 259);

        // Write mode, default strobe lengths.
        step();
        run_def(2'b01, 8'd4, rc, wc, ra);
        check("write.dir_out", dout_o[0], 8'd4);
        check("write.addr_err", err_o[0], 0);
        check("write.wr_cycles", wc, 256);
        check("write.rd_cycles", rc, 0);
        check("write.ready_cycle", ra, 258);

        // Abort at the second WR_PH cycle, then restart on the following cycle.
        step();
        start_v[1] = 1'b1; mode_v[1] = 2'b01; dir_v[1] = 8'd2;
        step();
        start_v[1] = 1'b0;
        step(); step();
        check("abort.wr_before", wr_o[1], 1);
        abort_v[1] = 1'b1;
        step();
        check("abort.wr", wr_o[1], 0);
        check("abort.busy", busy_o[1], 0);
        check("abort.pulse", ab_o[1], 1);
        check("abort.ready", ready_o[1], 0);
        check("abort.dir_kept", dout_o[1], 8'd2);
        abort_v[1] = 1'b0; start_v[1] = 1'b1; mode_v[1] = 2'b00; dir_v[1] = 8'd4;
        step();
        start_v[1] = 1'b0;
        check("abort.restart_busy", busy_o[1], 1);
        check("abort.pulse_once", ab_o[1], 0);
        nrdy = 0;
        repeat (10) begin
            step();
            nrdy += int'(ready_o[1]);
        end
        check("abort.restart_ready", nrdy, 1);

        // Start while busy is dropped; start with abort in IDLE is accepted.
        start_v[1] = 1'b1; mode_v[1] = 2'b00; dir_v[1] = 8'd2;
        step();
        start_v[1] = 1'b0;
        step();
        start_v[1] = 1'b1;
        step();
        start_v[1] = 1'b0;
        nrdy = 0;
        repeat (12) begin
            step();
            nrdy += int'(ready_o[1]);
        end
        check("busy_start.ready_count", nrdy, 1);
        start_v[1] = 1'b1; abort_v[1] = 1'b1;
        step();
        check("idle_abort.busy", busy_o[1], 1);
        check("idle_abort.aborted", ab_o[1], 0);
        quiet(1);
        wait_idle(1);

        // Random traffic on both instances against the model.
        for (int n = 0; n < 5000; n++) begin
            for (int i = 0; i < 2; i++) begin
                rstn_v[i]  = ($urandom_range(0, 1499) != 0);
                start_v[i] = ($urandom_range(0, 3) == 0);
                abort_v[i] = ($urandom_range(0, (i == 0) ? 399 : 24) == 0);
                mode_v[i]  = 2'($urandom_range(0, 3));
                dir_v[i]   = ($urandom_range(0, 7) == 0) ? 8'($urandom) :
                             8'($urandom_range(0, 6));
            end
            step();
        end
        quiet(0); quiet(1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
